alu_bist: RTL and testbench
===========================

Name: alu_bist

Overview:
- Synthesizable built-in self-test sequencer that drives the ALU operand/control interface from an internal vector table and checks `result`/`zero` against golden values.
- It is the initiator end of the ALU interface: the ALU stays a combinational responder, and this block issues the stimulus and judges the response.
- Sits beside the ALU in the base CPU. A mux selects BIST operands over datapath operands while `busy` is high, so ALU health can be checked on FPGA without a simulator.

Parameters:
- STOP_ON_FAIL, 0, 1 = end the run at the first mismatch; 0 = run all vectors and count failures.
- CHECK_ZERO, 1, 1 = compare the `zero` flag as well as `result`; 0 = compare `result` only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a run.
- alu_a  output  32  operand A to the ALU (registered).
- alu_b  output  32  operand B to the ALU (registered).
- alu_control  output  4  ALU op code (registered).
- alu_result  input  32  ALU result.
- alu_zero  input  1  ALU zero flag.
- busy  output  1  run in progress.
- done  output  1  run finished; held high until the next accepted start or reset.
- pass  output  1  valid while done: 1 iff fail_count == 0.
- fail_count  output  4  number of mismatching vectors in this run.
- fail_index  output  4  index of the first failing vector (4'hF if none).
- fail_result  output  32  alu_result captured at the first failure (0 if none).

Behaviour:
- Op codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, SRA 1101. Shift amount is b[4:0].
- Vector table (index: op a, b -> expected result, expected zero):
  - 0: ADD 10, 5 -> 15, 0
  - 1: SUB 10, 5 -> 5, 0
  - 2: AND F0F0F0F0, 0F0F0F0F -> 0, 1
  - 3: OR F0F00000, 00000F0F -> F0F00F0F, 0
  - 4: XOR FF00FF00, 00FF00FF -> FFFFFFFF, 0
  - 5: SLL 1, 5 -> 20, 0
  - 6: SRL 20, 5 -> 1, 0
  - 7: SRA FFFFFFE0, 5 -> FFFFFFFF, 0
  - 8: SLT FFFFFFFF, 5 -> 1, 0
  - 9: SLTU 1, FFFFFFFF -> 1, 0
  - 10: SUB 5, 5 -> 0, 1
  - All values hex except vectors 0-1 (decimal). NUM_VEC = 11, held as a case-based ROM.
- Reset (async, rst=1) puts the block in IDLE with:
  - alu_a = alu_b = 0, alu_control = 0
  - busy = done = pass = 0, fail_count = 0
  - fail_index = F, fail_result = 0, vector index = 0
- FSM states: IDLE, DRIVE, CHECK, DONE.
  - IDLE: start=1 -> DRIVE. On that edge: load vector 0 onto alu_* outputs, clear counters and fail_* to reset values, busy=1, done=0.
  - DRIVE: one settle cycle, outputs held -> CHECK unconditionally.
  - CHECK: on the edge, compare alu_result (and alu_zero if CHECK_ZERO) with the expected values.
    - Mismatch: fail_count += 1 (saturates at F). If this is the first failure, capture fail_index = idx and fail_result = alu_result.
    - If idx == 10, or a mismatch occurred with STOP_ON_FAIL=1 -> DONE.
    - Otherwise idx += 1, load the next vector -> DRIVE.
  - DONE: busy=0, done=1, pass = (fail_count == 0). alu_* hold the last vector. start=1 -> behaves exactly as start in IDLE (restart).
- Timing: each vector takes 2 cycles. With start sampled at edge E, vector i is checked at edge E+2i+2. A full run sets done at E+22.
- start while busy (DRIVE/CHECK) is ignored.
- rst asserted mid-run aborts immediately to the reset state; no partial results are retained.
- pass is only meaningful when done=1; it is 0 otherwise.

Test Plan:
- Golden behavioural ALU, pulse start -> busy for 22 cycles, then done=1, pass=1, fail_count=0, fail_index=F, fail_result=0.
- ALU with SRA implemented as a logical shift -> fail_count=1, fail_index=7, fail_result=07FFFFFF, pass=0, done at E+22.
- STOP_ON_FAIL=1, alu_zero stuck at 0 -> mismatch at vector 2, done at E+6, fail_count=1, fail_index=2.
- CHECK_ZERO=0 with alu_zero stuck at 0 and an otherwise golden ALU -> pass=1.
- Assert rst at E+9 -> all outputs return to reset values asynchronously. A new start then yields a clean full pass at +22.
- Pulse start at E+5 (ignored, timing unchanged). After done, pulse start again -> fail_* cleared and run repeats with identical results.

Source files
------------

// File: rtl/alu_if.sv
// ALU operand/control bus. The BIST drives operands as master and the
// combinational ALU answers as slave.
interface alu_if;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;

  modport master (output alu_a, alu_b, alu_control, input alu_result, alu_zero);
  modport slave  (input alu_a, alu_b, alu_control, output alu_result, alu_zero);
endinterface

// File: rtl/alu_bist.sv
// ALU built-in self-test: walks a fixed vector table over the ALU bus,
// spending one settle cycle and one check cycle per vector.
module alu_bist #(
  parameter bit STOP_ON_FAIL = 1'b0,
  parameter bit CHECK_ZERO   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  alu_if.master       alu,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_count,
  output logic [3:0]  fail_index,
  output logic [31:0] fail_result
);
  localparam logic [3:0] NUM_VEC = 4'd11;
  localparam logic [3:0] LAST    = NUM_VEC - 4'd1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  function automatic vec_t vec_rom(input logic [3:0] i);
    vec_t v;
    v = '0;
    case (i)
      4'd0:  v = '{OP_ADD,  32'd10,        32'd5,        32'd15,        1'b0};
      4'd1:  v = '{OP_SUB,  32'd10,        32'd5,        32'd5,         1'b0};
      4'd2:  v = '{OP_AND,  32'hF0F0F0F0,  32'h0F0F0F0F, 32'h00000000,  1'b1};
      4'd3:  v = '{OP_OR,   32'hF0F00000,  32'h00000F0F, 32'hF0F00F0F,  1'b0};
      4'd4:  v = '{OP_XOR,  32'hFF00FF00,  32'h00FF00FF, 32'hFFFFFFFF,  1'b0};
      4'd5:  v = '{OP_SLL,  32'h00000001,  32'h00000005, 32'h00000020,  1'b0};
      4'd6:  v = '{OP_SRL,  32'h00000020,  32'h00000005, 32'h00000001,  1'b0};
      4'd7:  v = '{OP_SRA,  32'hFFFFFFE0,  32'h00000005, 32'hFFFFFFFF,  1'b0};
      4'd8:  v = '{OP_SLT,  32'hFFFFFFFF,  32'h00000005, 32'h00000001,  1'b0};
      4'd9:  v = '{OP_SLTU, 32'h00000001,  32'hFFFFFFFF, 32'h00000001,  1'b0};
      4'd10: v = '{OP_SUB,  32'h00000005,  32'h00000005, 32'h00000000,  1'b1};
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [1:0] state;
  logic [3:0] idx;
  vec_t       cur, nxt, first;
  logic       mis;

  always_comb begin
    cur   = vec_rom(idx);
    nxt   = vec_rom(idx + 4'd1);
    first = vec_rom(4'd0);
    mis   = (alu.alu_result != cur.res) || (CHECK_ZERO && (alu.alu_zero != cur.zero));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      idx             <= '0;
      alu.alu_a       <= '0;
      alu.alu_b       <= '0;
      alu.alu_control <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_count      <= '0;
      fail_index      <= 4'hF;
      fail_result     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // DONE accepts start exactly like IDLE, so a restart wipes the last run
          if (start) begin
            state           <= S_DRIVE;
            idx             <= '0;
            alu.alu_a       <= first.a;
            alu.alu_b       <= first.b;
            alu.alu_control <= first.op;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= '0;
            fail_index      <= 4'hF;
            fail_result     <= '0;
          end
        end
        S_DRIVE: state <= S_CHECK;
        S_CHECK: begin
          if (mis) begin
            if (fail_count != 4'hF) fail_count <= fail_count + 4'd1;
            // count never wraps, so zero means no earlier failure in this run
            if (fail_count == 4'd0) begin
              fail_index  <= idx;
              fail_result <= alu.alu_result;
            end
          end
          if (idx == LAST || (mis && STOP_ON_FAIL)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_count == 4'd0) && !mis;
          end else begin
            state           <= S_DRIVE;
            idx             <= idx + 4'd1;
            alu.alu_a       <= nxt.a;
            alu.alu_b       <= nxt.b;
            alu.alu_control <= nxt.op;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: three instances (default, stop-on-fail with a
// stuck zero flag, zero-check disabled with a stuck zero flag) against a behavioural ALU.
module tb_alu_bist;
  logic clk = 1'b0;
  logic rst, start, sra_bug;
  always #5 clk = ~clk;

  alu_if m_if ();
  alu_if s_if ();
  alu_if z_if ();

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op, input logic sbug);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b0110: return a - b;
      4'b0111: return {31'd0, $signed(a) < $signed(b)};
      4'b1000: return {31'd0, a < b};
      4'b1101: return sbug ? (a >> b[4:0]) : 32'($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  assign m_if.alu_result = alu_fn(m_if.alu_a, m_if.alu_b, m_if.alu_control, sra_bug);
  assign m_if.alu_zero   = (m_if.alu_result == 32'd0);
  assign s_if.alu_result = alu_fn(s_if.alu_a, s_if.alu_b, s_if.alu_control, 1'b0);
  assign s_if.alu_zero   = 1'b0;
  assign z_if.alu_result = alu_fn(z_if.alu_a, z_if.alu_b, z_if.alu_control, 1'b0);
  assign z_if.alu_zero   = 1'b0;

  logic        m_busy, m_done, m_pass, s_busy, s_done, s_pass, z_busy, z_done, z_pass;
  logic [3:0]  m_fc, m_fi, s_fc, s_fi, z_fc, z_fi;
  logic [31:0] m_fr, s_fr, z_fr;

  alu_bist u_dut (.clk(clk), .rst(rst), .start(start), .alu(m_if.master),
    .busy(m_busy), .done(m_done), .pass(m_pass), .fail_count(m_fc),
    .fail_index(m_fi), .fail_result(m_fr));

  alu_bist #(.STOP_ON_FAIL(1'b1)) u_sof (.clk(clk), .rst(rst), .start(start), .alu(s_if.master),
    .busy(s_busy), .done(s_done), .pass(s_pass), .fail_count(s_fc),
    .fail_index(s_fi), .fail_result(s_fr));

  alu_bist #(.CHECK_ZERO(1'b0)) u_nz (.clk(clk), .rst(rst), .start(start), .alu(z_if.master),
    .busy(z_busy), .done(z_done), .pass(z_pass), .fail_count(z_fc),
    .fail_index(z_fi), .fail_result(z_fr));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // start is high across exactly one rising edge (edge E); returns at E+1ns
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // records the edge offset from E at which each instance first shows done
  task automatic wait_all(input int lat0, output int lm, output int ls, output int lz,
                          output int bc);
    int lat;
    lat = lat0; lm = -1; ls = -1; lz = -1; bc = 0;
    forever begin
      if (m_busy) bc++;
      if (lm < 0 && m_done) lm = lat;
      if (ls < 0 && s_done) ls = lat;
      if (lz < 0 && z_done) lz = lat;
      if ((lm >= 0 && ls >= 0 && lz >= 0) || lat >= 60) break;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_a"},    m_if.alu_a, 32'd0);
    check({pfx, "_b"},    m_if.alu_b, 32'd0);
    check({pfx, "_ctl"},  {28'd0, m_if.alu_control}, 32'd0);
    check({pfx, "_busy"}, {31'd0, m_busy}, 32'd0);
    check({pfx, "_done"}, {31'd0, m_done}, 32'd0);
    check({pfx, "_pass"}, {31'd0, m_pass}, 32'd0);
    check({pfx, "_fc"},   {28'd0, m_fc}, 32'd0);
    check({pfx, "_fi"},   {28'd0, m_fi}, 32'hF);
    check({pfx, "_fr"},   m_fr, 32'd0);
  endtask

  int lm, ls, lz, bc;

  initial begin
    rst = 1'b1; start = 1'b0; sra_bug = 1'b0;
    #3;
    check_reset_state("rst");
    @(negedge clk);
    rst = 1'b0;

    // golden run on all three instances
    pulse_start();
    check("load_a",   m_if.alu_a, 32'd10);
    check("load_b",   m_if.alu_b, 32'd5);
    check("load_ctl", {28'd0, m_if.alu_control}, 32'h2);
    check("run_busy", {31'd0, m_busy}, 32'd1);
    wait_all(0, lm, ls, lz, bc);
    check("gold_lat",  lm, 32'd22);
    check("gold_busy", bc, 32'd22);
    check("gold_pass", {31'd0, m_pass}, 32'd1);
    check("gold_fc",   {28'd0, m_fc}, 32'd0);
    check("gold_fi",   {28'd0, m_fi}, 32'hF);
    check("gold_fr",   m_fr, 32'd0);
    check("hold_a",    m_if.alu_a, 32'd5);
    check("hold_ctl",  {28'd0, m_if.alu_control}, 32'h6);
    check("sof_lat",   ls, 32'd6);
    check("sof_fc",    {28'd0, s_fc}, 32'd1);
    check("sof_fi",    {28'd0, s_fi}, 32'd2);
    check("sof_fr",    s_fr, 32'd0);
    check("sof_pass",  {31'd0, s_pass}, 32'd0);
    check("nz_lat",    lz, 32'd22);
    check("nz_pass",   {31'd0, z_pass}, 32'd1);

    // SRA wired as a logical shift
    sra_bug = 1'b1;
    pulse_start();
    wait_all(0, lm, ls, lz, bc);
    check("sra_lat",  lm, 32'd22);
    check("sra_fc",   {28'd0, m_fc}, 32'd1);
    check("sra_fi",   {28'd0, m_fi}, 32'd7);
    check("sra_fr",   m_fr, 32'h07FFFFFF);
    check("sra_pass", {31'd0, m_pass}, 32'd0);

    // restart from DONE clears the previous results, then repeats them
    pulse_start();
    check("rs_fc",   {28'd0, m_fc}, 32'd0);
    check("rs_fi",   {28'd0, m_fi}, 32'hF);
    check("rs_fr",   m_fr, 32'd0);
    check("rs_done", {31'd0, m_done}, 32'd0);
    check("rs_busy", {31'd0, m_busy}, 32'd1);
    wait_all(0, lm, ls, lz, bc);
    check("rs2_lat", lm, 32'd22);
    check("rs2_fc",  {28'd0, m_fc}, 32'd1);
    check("rs2_fi",  {28'd0, m_fi}, 32'd7);
    check("rs2_fr",  m_fr, 32'h07FFFFFF);
    sra_bug = 1'b0;

    // start while busy at E+5 is ignored
    pulse_start();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_all(5, lm, ls, lz, bc);
    check("ign_lat",  lm, 32'd22);
    check("ign_pass", {31'd0, m_pass}, 32'd1);
    check("ign_sof",  ls, 32'd6);

    // asynchronous reset mid-run, then a clean run
    pulse_start();
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_state("abort");
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    wait_all(0, lm, ls, lz, bc);
    check("post_lat",  lm, 32'd22);
    check("post_pass", {31'd0, m_pass}, 32'd1);
    check("post_fc",   {28'd0, m_fc}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
